// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the core port (C) and the debug/loader port (D).
// Round-robin or fixed-priority grant; every access ends with a one-cycle ready pulse to its owner.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_d,
  output logic              busy
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
  end

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                pick_d;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    pick_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          // D wins when alone, or on a round-robin tie when C was served last.
          pick_d       = d_req && (!c_req || (FIXED_PRIO == 0 && !last_grant_q));
          win_d        = pick_d;
          last_grant_d = pick_d;
          we_d         = pick_d ? d_we    : c_we;
          addr_d       = pick_d ? d_addr  : c_addr;
          wdata_d      = pick_d ? d_wdata : c_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to D so that C wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant_d   = win_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign c_ready   = (state_q == RESP) && !win_q;
  assign d_ready   = (state_q == RESP) &&  win_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: four instances (RR L=2, fixed-prio L=2, RR L=1, RR L=15)
// share the requester stimulus; each has its own delay-line memory model.
module tb_mem_port_arbiter;

  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;

  logic        cr_v [NDUT];
  logic        dr_v [NDUT];
  logic        en_v [NDUT];
  logic        we_v [NDUT];
  logic        gd_v [NDUT];
  logic        busy_v [NDUT];
  logic [31:0] rdata_v [NDUT];
  logic [31:0] addr_v [NDUT];
  logic [31:0] wdata_v [NDUT];
  logic [31:0] mrd_v [NDUT];

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 1 : (g == 3) ? 15 : 2;
    logic [31:0] pipe [16];

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .FIXED_PRIO((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(cr_v[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(dr_v[g]),
      .rdata(rdata_v[g]), .mem_en(en_v[g]), .mem_we(we_v[g]), .mem_addr(addr_v[g]),
      .mem_wdata(wdata_v[g]), .mem_rdata(mrd_v[g]), .grant_d(gd_v[g]), .busy(busy_v[g])
    );

    // Read data is valid only LAT cycles after the issue cycle; filler elsewhere.
    always @(posedge clk) begin
      for (int i = 15; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= en_v[g] ? mem[addr_v[g][7:2]] : (32'hBAD0_0000 + g);
    end
    assign mrd_v[g] = pipe[LAT-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    #1 reset = 1'b1;
    #2;
    for (int g = 0; g < NDUT; g++) begin
      checks++;
      if ({en_v[g], we_v[g], cr_v[g], dr_v[g], gd_v[g], busy_v[g]} !== 6'b0 ||
          addr_v[g] !== 32'h0 || wdata_v[g] !== 32'h0 || rdata_v[g] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: en=%b we=%b cr=%b dr=%b gd=%b busy=%b addr=%h wdata=%h rdata=%h, required all 0",
                 g, en_v[g], we_v[g], cr_v[g], dr_v[g], gd_v[g], busy_v[g], addr_v[g], wdata_v[g], rdata_v[g]);
      end
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b required 0", busy_v[0]);
    end
  endtask

  task automatic test_c_read();
    do_reset();
    mem[4] = 32'hDEAD_BEEF;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      checks++;
      if (en_v[0] !== (cyc == 1) || cr_v[0] !== (cyc == 4) || dr_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL c_read cycle %0d: mem_en=%b c_ready=%b d_ready=%b, required %b %b 0",
                 cyc, en_v[0], cr_v[0], dr_v[0], cyc == 1, cyc == 4);
      end
      if (cyc == 4) begin
        checks++;
        if (rdata_v[0] !== 32'hDEAD_BEEF) begin
          errors++;
          $display("FAIL c_read_data: rdata=%h required deadbeef", rdata_v[0]);
        end
      end
      if (cr_v[0]) c_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_d_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
    tick();
    checks++;
    if (en_v[0] !== 1'b1 || we_v[0] !== 1'b1 || addr_v[0] !== 32'h40 ||
        wdata_v[0] !== 32'h1234_5678 || gd_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL d_write_issue: en=%b we=%b addr=%h wdata=%h gd=%b, required 1 1 40 12345678 1",
               en_v[0], we_v[0], addr_v[0], wdata_v[0], gd_v[0]);
    end
    tick();
    checks++;
    if (dr_v[0] !== 1'b1 || cr_v[0] !== 1'b0 || en_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL d_write_ready: d_ready=%b c_ready=%b en=%b, required 1 0 0", dr_v[0], cr_v[0], en_v[0]);
    end
    d_req = 1'b0;
    tick();
    checks++;
    if (dr_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || rdata_v[0] !== 32'hDEAD_BEEF || addr_v[0] !== 32'h40) begin
      errors++;
      $display("FAIL d_write_after: d_ready=%b busy=%b rdata=%h addr=%h, required 0 0 deadbeef 40",
               dr_v[0], busy_v[0], rdata_v[0], addr_v[0]);
    end
  endtask

  task automatic test_arbitration();
    int          n0 = 0, n1 = 0;
    logic [3:0]  seq0 = '0, seq1 = '1;
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (en_v[0] && n0 < 4) begin seq0[n0] = gd_v[0]; n0++; end
      if (en_v[1] && n1 < 4) begin seq1[n1] = gd_v[1]; n1++; end
      for (int g = 0; g < NDUT; g++) begin
        checks++;
        if (cr_v[g] && dr_v[g]) begin
          errors++;
          $display("FAIL ready_exclusive dut%0d cycle %0d: c_ready=1 d_ready=1, required not both", g, cyc);
        end
      end
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n0 !== 4 || seq0 !== 4'b1010) begin
      errors++;
      $display("FAIL rr_alternate: %0d grants seq=%b, required 4 grants seq=1010 (C,D,C,D)", n0, seq0);
    end
    checks++;
    if (n1 !== 4 || seq1 !== 4'b0000) begin
      errors++;
      $display("FAIL fixed_prio: %0d grants seq=%b, required 4 grants seq=0000 (all C)", n1, seq1);
    end
  endtask

  task automatic test_pending_req();
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hA5A5_0001;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      if (cyc == 2) d_req = 1'b1;
      checks++;
      if (en_v[0] !== (cyc == 1 || cyc == 6) || cr_v[0] !== (cyc == 4) || dr_v[0] !== (cyc == 7)) begin
        errors++;
        $display("FAIL pending cycle %0d: mem_en=%b c_ready=%b d_ready=%b, required %b %b %b",
                 cyc, en_v[0], cr_v[0], dr_v[0], cyc == 1 || cyc == 6, cyc == 4, cyc == 7);
      end
      if (cyc == 6) begin
        checks++;
        if (gd_v[0] !== 1'b1 || we_v[0] !== 1'b1 || addr_v[0] !== 32'h80 || wdata_v[0] !== 32'hA5A5_0001) begin
          errors++;
          $display("FAIL pending_d_issue: gd=%b we=%b addr=%h wdata=%h, required 1 1 80 a5a50001",
                   gd_v[0], we_v[0], addr_v[0], wdata_v[0]);
        end
      end
      if (cr_v[0]) c_req = 1'b0;
      if (dr_v[0]) d_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    mem[4] = 32'hDEAD_BEEF;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
    tick();
    tick();
    checks++;
    if (busy_v[0] !== 1'b1 || en_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_wait: busy=%b en=%b, required 1 0", busy_v[0], en_v[0]);
    end
    #2 reset = 1'b1;
    c_req = 1'b0;
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || en_v[0] !== 1'b0 || cr_v[0] !== 1'b0 || dr_v[0] !== 1'b0 || rdata_v[0] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b en=%b cr=%b dr=%b rdata=%h, required all 0",
               busy_v[0], en_v[0], cr_v[0], dr_v[0], rdata_v[0]);
    end
    tick();
    reset = 1'b0;
    mem[4] = 32'hCAFE_F00D;
    c_req = 1'b1;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      checks++;
      if (cr_v[0] !== (cyc == 4) || dr_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL reread cycle %0d: c_ready=%b d_ready=%b, required %b 0", cyc, cr_v[0], dr_v[0], cyc == 4);
      end
      if (cyc == 4) begin
        checks++;
        if (rdata_v[0] !== 32'hCAFE_F00D) begin
          errors++;
          $display("FAIL reread_data: rdata=%h required cafef00d", rdata_v[0]);
        end
      end
      if (cr_v[0]) c_req = 1'b0;
      tick();
    end
  endtask

  task automatic test_latency_sweep();
    int          found2 = -1, found3 = -1;
    logic [31:0] data3 = '0;
    do_reset();
    mem[5] = 32'h5EED_0015;
    mem[6] = 32'h5EED_0018;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h14;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h18;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (cr_v[2] && found2 < 0) found2 = cyc;
      if (cr_v[3] && found3 < 0) begin found3 = cyc; data3 = rdata_v[3]; end
      for (int g = 0; g < NDUT; g++) begin
        checks++;
        if (cr_v[g] && dr_v[g]) begin
          errors++;
          $display("FAIL ready_exclusive dut%0d cycle %0d: c_ready=1 d_ready=1, required not both", g, cyc);
        end
      end
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    checks++;
    if (found2 !== 3) begin
      errors++;
      $display("FAIL latency_1: c_ready first at cycle %0d, required 3", found2);
    end
    checks++;
    if (found3 !== 17 || data3 !== 32'h5EED_0015) begin
      errors++;
      $display("FAIL latency_15: c_ready first at cycle %0d rdata=%h, required 17 5eed0015", found3, data3);
    end
  endtask

  initial begin
    test_reset();
    test_c_read();
    test_d_write();
    test_arbitration();
    test_pending_req();
    test_reset_mid_read();
    test_latency_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
